// File: rtl/scene_sprite_renderer.sv
// Per-pixel hit test for the VGA scene: player box, open-top U obstacle and
// a scrolling field of sine-modulated bars hanging from a top baseline and
// rising to a bottom baseline. All three flags are registered.
module scene_sprite_renderer #(
  parameter int unsigned PLAYER_X = 32,
  parameter int unsigned PLAYER_W = 16,
  parameter int unsigned PLAYER_H = 16,
  parameter int unsigned U_W      = 40,
  parameter int unsigned U_H      = 40,
  parameter int unsigned U_T      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic [9:0] player_y,
  input  logic       show_player,
  input  logic [9:0] u_x,
  input  logic [9:0] u_y,
  input  logic [9:0] x_offset,
  input  logic [9:0] top_x,
  input  logic [9:0] top_y,
  input  logic [9:0] bottom_x,
  input  logic [9:0] bottom_y,
  input  logic [9:0] bar_width,
  input  logic [9:0] visible_width,
  input  logic [9:0] height,
  output logic       draw_player,
  output logic       draw_u,
  output logic       draw_double_sin
);

  // Upper bounds are kept 11 bits wide so boxes near the 1023 edge never wrap.
  localparam logic [10:0] PLAYER_X_LO = 11'(PLAYER_X);
  localparam logic [10:0] PLAYER_X_HI = 11'(PLAYER_X + PLAYER_W);
  localparam logic [10:0] PLAYER_H_11 = 11'(PLAYER_H);
  localparam logic [10:0] U_W_11      = 11'(U_W);
  localparam logic [10:0] U_H_11      = 11'(U_H);
  localparam logic [9:0]  U_ARM       = 10'(U_T);
  localparam logic [9:0]  U_RIGHT_ARM = 10'(U_W - U_T);
  localparam logic [9:0]  U_BASE      = 10'(U_H - U_T);

  logic hit_player;
  logic hit_u;
  logic hit_sin;

  logic       u_inside;
  logic [9:0] u_rx;
  logic [9:0] u_ry;

  logic       sin_active;
  logic [9:0] sin_local;
  logic [9:0] sin_divisor;
  logic [3:0] sin_idx;
  logic [9:0] sin_phase;
  logic [7:0] lut_top;
  logic [7:0] lut_bot;
  logic [9:0] top_len;
  logic [9:0] bot_len;
  logic       top_hit;
  logic       bot_hit;

  // One period of a sine sampled at 16 points, offset to 0..255.
  function automatic logic [7:0] sine_lut(input logic [3:0] idx);
    logic [7:0] val;
    case (idx)
      4'd0:    val = 8'd128;
      4'd1:    val = 8'd176;
      4'd2:    val = 8'd218;
      4'd3:    val = 8'd245;
      4'd4:    val = 8'd255;
      4'd5:    val = 8'd245;
      4'd6:    val = 8'd218;
      4'd7:    val = 8'd176;
      4'd8:    val = 8'd128;
      4'd9:    val = 8'd79;
      4'd10:   val = 8'd37;
      4'd11:   val = 8'd10;
      4'd12:   val = 8'd0;
      4'd13:   val = 8'd10;
      4'd14:   val = 8'd37;
      default: val = 8'd79;
    endcase
    return val;
  endfunction

  // Player box at a fixed column, vertical position from the game logic.
  always_comb begin
    hit_player = show_player
              && ({1'b0, pix_x} >= PLAYER_X_LO)
              && ({1'b0, pix_x} <  PLAYER_X_HI)
              && (pix_y >= player_y)
              && ({1'b0, pix_y} < ({1'b0, player_y} + PLAYER_H_11));
  end

  // U obstacle: two arms plus a base, top left open.
  always_comb begin
    u_rx     = pix_x - u_x;
    u_ry     = pix_y - u_y;
    u_inside = (pix_x >= u_x) && ({1'b0, pix_x} < ({1'b0, u_x} + U_W_11))
            && (pix_y >= u_y) && ({1'b0, pix_y} < ({1'b0, u_y} + U_H_11));
    hit_u    = u_inside && ((u_rx < U_ARM) || (u_rx >= U_RIGHT_ARM) || (u_ry >= U_BASE));
  end

  // Sine bar field. The bottom row uses the LUT half a period ahead so the
  // two rows move in anti-phase. The bottom lower bound is tested as
  // pix_y + bot_len >= bottom_y to avoid an underflowing subtraction.
  always_comb begin
    sin_active  = (pix_x >= top_x) && (pix_x < bottom_x) && (bar_width != 10'd0);
    sin_local   = pix_x - top_x + x_offset;
    sin_divisor = (bar_width == 10'd0) ? 10'd1 : bar_width;
    sin_idx     = 4'(sin_local / sin_divisor);
    sin_phase   = sin_local % sin_divisor;
    lut_top     = sine_lut(sin_idx);
    lut_bot     = sine_lut(sin_idx + 4'd8);
    top_len     = 10'(({10'b0, lut_top} * {8'b0, height}) >> 8);
    bot_len     = 10'(({10'b0, lut_bot} * {8'b0, height}) >> 8);
    top_hit     = (pix_y >= top_y) && ({1'b0, pix_y} < ({1'b0, top_y} + {1'b0, top_len}));
    bot_hit     = (pix_y < bottom_y) && (({1'b0, pix_y} + {1'b0, bot_len}) >= {1'b0, bottom_y});
    hit_sin     = sin_active && (sin_phase < visible_width) && (top_hit || bot_hit);
  end

  // Register the hit flags for the downstream colour mux.
  always_ff @(posedge clk) begin
    if (rst) begin
      draw_player     <= 1'b0;
      draw_u          <= 1'b0;
      draw_double_sin <= 1'b0;
    end else begin
      draw_player     <= hit_player;
      draw_u          <= hit_u;
      draw_double_sin <= hit_sin;
    end
  end

endmodule

// File: tb/tb_scene_sprite_renderer.sv
// Scoreboard bench: the driver pushes the expected flags for every pixel it
// presents, the monitor pops one entry per clock after the edge.
module tb_scene_sprite_renderer;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] pix_x, pix_y, player_y, u_x, u_y, x_offset;
  logic [9:0] top_x, top_y, bottom_x, bottom_y, bar_width, visible_width, height;
  logic       show_player;
  logic       draw_player, draw_u, draw_double_sin;

  typedef struct {
    logic  p;
    logic  u;
    logic  s;
    string name;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   sine_tab[16] = '{128,176,218,245,255,245,218,176,128,79,37,10,0,10,37,79};

  scene_sprite_renderer dut (
    .clk(clk), .rst(rst), .pix_x(pix_x), .pix_y(pix_y),
    .player_y(player_y), .show_player(show_player), .u_x(u_x), .u_y(u_y),
    .x_offset(x_offset), .top_x(top_x), .top_y(top_y), .bottom_x(bottom_x),
    .bottom_y(bottom_y), .bar_width(bar_width), .visible_width(visible_width),
    .height(height), .draw_player(draw_player), .draw_u(draw_u),
    .draw_double_sin(draw_double_sin)
  );

  always #5 clk = ~clk;

  // Reference model: straight from the geometric rules, with int arithmetic.
  function automatic logic ref_player();
    int px = int'(pix_x), py = int'(pix_y), top = int'(player_y);
    return show_player && px >= 32 && px < 48 && py >= top && py < top + 16;
  endfunction

  function automatic logic ref_u();
    int rx = int'(pix_x) - int'(u_x);
    int ry = int'(pix_y) - int'(u_y);
    if (rx < 0 || rx >= 40 || ry < 0 || ry >= 40) return 1'b0;
    return rx < 8 || rx >= 32 || ry >= 32;
  endfunction

  function automatic logic ref_sin();
    int lx, idx, phase, tl, bl, py;
    if (!(pix_x >= top_x && pix_x < bottom_x) || bar_width == 0) return 1'b0;
    lx    = (int'(pix_x) - int'(top_x) + int'(x_offset) + 2048) % 1024;
    idx   = lx / int'(bar_width);
    phase = lx % int'(bar_width);
    if (phase >= int'(visible_width)) return 1'b0;
    tl = sine_tab[idx % 16] * int'(height) / 256;
    bl = sine_tab[(idx + 8) % 16] * int'(height) / 256;
    py = int'(pix_y);
    return (py >= int'(top_y) && py < int'(top_y) + tl)
        || (py < int'(bottom_y) && py >= int'(bottom_y) - bl);
  endfunction

  // Present the current input set for one cycle and queue its expectation.
  task automatic drive(input string name);
    exp_t e;
    if (rst) begin
      e.p = 1'b0; e.u = 1'b0; e.s = 1'b0;
    end else begin
      e.p = ref_player(); e.u = ref_u(); e.s = ref_sin();
    end
    e.name = name;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Directed pixel whose expected value for one flag is given outright.
  task automatic drive_k(input string name, input int which, input logic val);
    exp_t e;
    e.p = ref_player(); e.u = ref_u(); e.s = ref_sin();
    case (which)
      0: e.p = val;
      1: e.u = val;
      default: e.s = val;
    endcase
    e.name = name;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic check(input string name, input string sig, input logic act, input logic req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s %s: got %0b required %0b", name, sig, act, req);
    end
  endtask

  // Monitor: one result per clock, taken just after the active edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(e.name, "draw_player", draw_player, e.p);
      check(e.name, "draw_u", draw_u, e.u);
      check(e.name, "draw_double_sin", draw_double_sin, e.s);
    end
  end

  task automatic set_field();
    top_x = 100; top_y = 180; bottom_x = 540; bottom_y = 400;
    bar_width = 40; visible_width = 25; height = 60; x_offset = 0;
  endtask

  task automatic px(input int x, input int y);
    pix_x = 10'(x); pix_y = 10'(y);
  endtask

  initial begin
    rst = 1'b1;
    player_y = 200; show_player = 1'b1; u_x = 700; u_y = 700;
    set_field(); bar_width = 0;
    px(40, 205);
    @(negedge clk);
    drive("reset0");
    drive("reset1");
    rst = 1'b0;
    drive_k("reset_release", 0, 1'b1);

    px(40, 205); drive_k("player_in", 0, 1'b1);
    px(40, 216); drive_k("player_below", 0, 1'b0);
    px(31, 205); drive_k("player_left", 0, 1'b0);
    px(47, 215); drive_k("player_corner", 0, 1'b1);
    show_player = 1'b0;
    px(40, 205); drive_k("hidden_in", 0, 1'b0);
    px(47, 215); drive_k("hidden_corner", 0, 1'b0);
    show_player = 1'b1;

    u_x = 100; u_y = 100;
    px(104, 110); drive_k("u_left_arm", 1, 1'b1);
    px(120, 110); drive_k("u_hollow", 1, 1'b0);
    px(120, 135); drive_k("u_base", 1, 1'b1);
    px(135, 110); drive_k("u_right_arm", 1, 1'b1);
    px(140, 110); drive_k("u_right_out", 1, 1'b0);
    px(120, 99);  drive_k("u_above", 1, 1'b0);
    u_x = 700; u_y = 700;

    set_field();
    px(100, 200); drive_k("sin_top_in", 2, 1'b1);
    px(100, 210); drive_k("sin_top_end", 2, 1'b0);
    px(100, 385); drive_k("sin_bot_in", 2, 1'b1);
    px(100, 400); drive_k("sin_bot_end", 2, 1'b0);
    px(130, 200); drive_k("sin_dark_phase", 2, 1'b0);
    px(140, 220); drive_k("sin_idx1_last", 2, 1'b1);
    px(140, 221); drive_k("sin_idx1_past", 2, 1'b0);
    x_offset = 40;
    px(100, 220); drive_k("sin_scroll", 2, 1'b1);
    x_offset = 0;
    px(540, 200); drive_k("sin_right_bound", 2, 1'b0);
    px(99, 200);  drive_k("sin_left_bound", 2, 1'b0);
    bar_width = 0;
    px(100, 200); drive_k("sin_bw0_top", 2, 1'b0);
    px(100, 385); drive_k("sin_bw0_bot", 2, 1'b0);
    bar_width = 40; height = 0;
    px(100, 180); drive_k("sin_h0_top", 2, 1'b0);
    px(100, 399); drive_k("sin_h0_bot", 2, 1'b0);
    height = 60;

    // Mid-frame reset with a hitting pixel on the inputs.
    px(100, 200); rst = 1'b1; drive("midframe_reset");
    rst = 1'b0;

    for (int x = 100; x <= 140; x++) begin
      px(x, 200);
      drive("sweep");
    end

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        top_x = 10'($urandom_range(0, 400));
        bottom_x = 10'(int'(top_x) + $urandom_range(0, 600));
        top_y = 10'($urandom_range(0, 500));
        height = 10'($urandom_range(0, 200));
        bottom_y = 10'($urandom_range(int'(height), 1023));
        bar_width = 10'($urandom_range(0, 64));
        visible_width = 10'($urandom_range(0, 64));
        x_offset = 10'($urandom);
        u_x = 10'($urandom_range(0, 1000));
        u_y = 10'($urandom_range(0, 1000));
        player_y = 10'($urandom_range(0, 1020));
        show_player = 1'($urandom_range(0, 3) != 0);
      end
      case ($urandom_range(0, 4))
        0: px($urandom_range(0, 1023), $urandom_range(0, 1023));
        1: px($urandom_range(28, 52), int'(player_y) + $urandom_range(0, 20) - 2);
        2: px(int'(u_x) + $urandom_range(0, 44) - 2, int'(u_y) + $urandom_range(0, 44) - 2);
        3: px(int'(top_x) + $urandom_range(0, 600) - 2, int'(top_y) + $urandom_range(0, 210) - 2);
        default: px(int'(top_x) + $urandom_range(0, 600) - 2, int'(bottom_y) - $urandom_range(0, 210) + 2);
      endcase
      rst = ($urandom_range(0, 99) == 0);
      drive("random");
    end
    rst = 1'b0;

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/scene_sprite_renderer.md
Name: scene_sprite_renderer

Overview:
- Per-pixel hit-test unit for the VGA scene.
- For each (pix_x, pix_y) it decides whether three sprites cover the pixel:
  - the player box
  - a U-shaped obstacle
  - a scrolling double-sine bar field (top and bottom rows)
- All hit flags are registered (1-cycle latency) and feed the colour mux downstream.

Parameters:
- PLAYER_X, 32, fixed left edge of player box (pixels)
- PLAYER_W, 16, player box width
- PLAYER_H, 16, player box height
- U_W, 40, U-shape outer width
- U_H, 40, U-shape outer height
- U_T, 8, U-shape arm/base thickness

Ports:
- clk  input  1  pixel clock
- rst  input  1  synchronous active-high reset
- pix_x  input  10  current pixel column
- pix_y  input  10  current pixel row
- player_y  input  10  player top edge
- show_player  input  1  enables player drawing
- u_x  input  10  U-shape left edge
- u_y  input  10  U-shape top edge
- x_offset  input  10  horizontal scroll of the sine field
- top_x  input  10  sine field left bound (inclusive)
- top_y  input  10  top-row baseline; top bars hang down from it
- bottom_x  input  10  sine field right bound (exclusive)
- bottom_y  input  10  bottom-row baseline; bottom bars rise up to it (exclusive)
- bar_width  input  10  bar pitch in pixels
- visible_width  input  10  lit width of each bar within the pitch
- height  input  10  maximum bar length
- draw_player  output  1  player covers pixel
- draw_u  output  1  U-shape covers pixel
- draw_double_sin  output  1  any sine bar covers pixel

Behaviour:
- Reset: one clock with rst=1 clears all three outputs to 0 on that edge, including mid-frame; the next evaluated pixel appears one cycle after rst falls.
- Latency: outputs reflect inputs sampled at the previous rising edge; no handshake; new pixel accepted every cycle.
- All comparisons are unsigned 10-bit. Upper bounds (pos + size) are computed 11 bits wide, with no wrap.
- Player: draw_player = show_player AND PLAYER_X <= pix_x < PLAYER_X+PLAYER_W AND player_y <= pix_y < player_y+PLAYER_H.
- U-shape (bounding-box relative):
  - rx = pix_x-u_x, ry = pix_y-u_y.
  - Inside box means u_x <= pix_x < u_x+U_W AND u_y <= pix_y < u_y+U_H.
  - draw_u = inside box AND (rx < U_T OR rx >= U_W-U_T OR ry >= U_H-U_T). The top is open.
- Double sine:
  - Active only when top_x <= pix_x < bottom_x AND bar_width != 0; otherwise 0.
  - local = (pix_x - top_x + x_offset) mod 1024.
  - idx = local / bar_width; phase = local % bar_width (unsigned integer divide/modulo).
  - Lit column when phase < visible_width.
  - Internal 16-entry sine LUT, 8-bit, index 0..15: 128,176,218,245,255,245,218,176,128,79,37,10,0,10,37,79.
  - top_len = (LUT[idx[3:0]] * height) >> 8; bot_len = (LUT[(idx+8)[3:0]] * height) >> 8. Product is 18-bit unsigned; the result is always <= height.
  - top hit: top_y <= pix_y < top_y+top_len. bottom hit: bottom_y-bot_len <= pix_y < bottom_y.
  - draw_double_sin = active AND lit AND (top hit OR bottom hit).
  - A length of 0 draws nothing in that row.
- Outputs are independent; simultaneous hits are all reported.

Test Plan:
- rst=1 for 2 cycles while pixel (40,205) would hit -> all outputs 0. Release rst -> draw_player=1 one cycle later (player_y=200, show_player=1).
- Player: player_y=200, pixels (40,205)/(40,216)/(31,205)/(47,215) -> 1/0/0/1. The same pixels with show_player=0 -> all 0.
- U at (100,100): pixels (104,110)/(120,110)/(120,135)/(135,110)/(140,110)/(120,99) -> 1/0/1/1/0/0.
- Sine field setup: top=(100,180), bottom=(540,400), bar 40, visible 25, height 60, x_offset 0.
  - (100,200)/(100,210) -> 1/0 (top_len 30).
  - (100,385)/(100,400) -> 1/0 (bot_len 30).
  - (130,200) -> 0 (phase 30).
  - (140,220) -> 1 (idx1, top_len 41); (140,221) -> 0.
- Scroll and bounds, same field setup:
  - x_offset=40, pixel (100,220) -> 1 (matches idx1).
  - pix_x=540 or 99 -> 0.
  - bar_width=0 -> 0 everywhere.
  - height=0 -> 0 everywhere.
- Back-to-back pixels every cycle across x=100..140 at y=200: output sequence equals the per-pixel spec delayed by exactly 1 cycle.
